// File: rtl/router_pkg.sv
// router_pkg: shared constants for the 5-port mesh router slice.
// Port indices, flit field offsets, channel width and RR step helpers.
package router_pkg;

    localparam int NUM_PORTS = 5;

    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int WEST  = 2;
    localparam int NORTH = 3;
    localparam int SOUTH = 4;

    localparam int VALID    = 0;
    localparam int HEAD     = 1;
    localparam int TAIL     = 2;
    localparam int DATA_LSB = 3;

    typedef logic [2:0] port_idx_t;

    function automatic int channel_width(input int data_width);
        return DATA_LSB + data_width;
    endfunction

    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NUM_PORTS - 1)) ? '0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/router_input_buffer.sv
// router_input_buffer: circular input FIFO for one router port.
// Ports: wr_en/wr_data push, rd_en pop, rd_data front, empty, overflow, credit pulse.
module router_input_buffer
    import router_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             overflow,
    output logic             credit
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign overflow = wr_en && full;
    assign credit   = do_rd;
    assign rd_data  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ONE;
            if (do_rd) rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/router_slice_buffered.sv
// router_slice_buffered: 5-port XY wormhole router, input FIFOs, credits, RR arbiters.
// Ports: router_address, channel_in_ip/flow_ctrl_out_ip per input, channel_out_op/flow_ctrl_in_op per output, error.
module router_slice_buffered
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int FLIT_DATA_WIDTH = 31,
    parameter int BUF_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] router_address,
    input  logic [NUM_PORTS*channel_width(FLIT_DATA_WIDTH)-1:0] channel_in_ip,
    input  logic [NUM_PORTS-1:0]  flow_ctrl_in_op,
    output logic                  error,
    output logic [NUM_PORTS*channel_width(FLIT_DATA_WIDTH)-1:0] channel_out_op,
    output logic [NUM_PORTS-1:0]  flow_ctrl_out_ip
);

    localparam int CW  = channel_width(FLIT_DATA_WIDTH);
    localparam int SW  = CW - 1;
    localparam int HW  = ADDR_WIDTH / 2;
    localparam int CRW = $clog2(BUF_DEPTH + 1);
    localparam logic [CRW-1:0] CRED_MAX = CRW'(BUF_DEPTH);
    localparam logic [CRW-1:0] CRED_ONE = CRW'(1);
    // FIFOs store flits without the valid bit: fields sit one lower.
    localparam int S_HEAD = HEAD - 1;
    localparam int S_TAIL = TAIL - 1;
    localparam int S_DEST = DATA_LSB - 1;

    logic [SW-1:0]        front [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] overflow;
    logic [NUM_PORTS-1:0] rd_en;

    logic [NUM_PORTS-1:0] lock_vld;
    port_idx_t            lock_src [NUM_PORTS];
    port_idx_t            rr_ptr   [NUM_PORTS];
    logic [CRW-1:0]       credit   [NUM_PORTS];
    logic [CW-1:0]        out_q    [NUM_PORTS];

    port_idx_t            route    [NUM_PORTS];
    logic [NUM_PORTS-1:0] is_head;
    logic [NUM_PORTS-1:0] is_tail;
    logic [NUM_PORTS-1:0] in_locked;
    logic [NUM_PORTS-1:0] orphan;
    logic [NUM_PORTS-1:0] uturn;
    logic [NUM_PORTS-1:0] send;
    logic [NUM_PORTS-1:0] cred_ovf;
    port_idx_t            send_src [NUM_PORTS];
    port_idx_t            idx;

    function automatic port_idx_t xy_route(
        input logic [ADDR_WIDTH-1:0] dst,
        input logic [ADDR_WIDTH-1:0] here
    );
        logic [HW-1:0] dx, dy, cx, cy;
        dx = dst[ADDR_WIDTH-1:HW];
        dy = dst[HW-1:0];
        cx = here[ADDR_WIDTH-1:HW];
        cy = here[HW-1:0];
        if (dx > cx) return port_idx_t'(EAST);
        if (dx < cx) return port_idx_t'(WEST);
        if (dy > cy) return port_idx_t'(NORTH);
        if (dy < cy) return port_idx_t'(SOUTH);
        return port_idx_t'(LOCAL);
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_input_buffer #(
            .WIDTH (SW),
            .DEPTH (BUF_DEPTH)
        ) u_buf (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (channel_in_ip[p*CW+VALID]),
            .wr_data  (channel_in_ip[p*CW+HEAD +: SW]),
            .rd_en    (rd_en[p]),
            .rd_data  (front[p]),
            .empty    (empty[p]),
            .overflow (overflow[p]),
            .credit   (flow_ctrl_out_ip[p])
        );
        assign channel_out_op[p*CW +: CW] = out_q[p];
    end

    always_comb begin
        in_locked = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (lock_vld[o]) in_locked[lock_src[o]] = 1'b1;
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            is_head[i] = front[i][S_HEAD];
            is_tail[i] = front[i][S_TAIL];
            route[i]   = xy_route(front[i][S_DEST +: ADDR_WIDTH],
                                  router_address);
            // A body flit with no owning output cannot go anywhere.
            orphan[i]  = !empty[i] && !is_head[i] && !in_locked[i];
            uturn[i]   = !empty[i] && is_head[i] && !in_locked[i] &&
                         (i != LOCAL) && (route[i] == port_idx_t'(i));
        end

        idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            send[o]     = 1'b0;
            send_src[o] = '0;
            if (lock_vld[o]) begin
                // Locked outputs wait on their owner; no bubble-fill.
                send_src[o] = lock_src[o];
                send[o]     = !empty[lock_src[o]] && (credit[o] != '0);
            end else if (credit[o] != '0) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = port_idx_t'((int'(rr_ptr[o]) + k) % NUM_PORTS);
                    if (!send[o] && !empty[idx] && is_head[idx] &&
                        !in_locked[idx] &&
                        route[idx] == port_idx_t'(o)) begin
                        send[o]     = 1'b1;
                        send_src[o] = idx;
                    end
                end
            end
            cred_ovf[o] = flow_ctrl_in_op[o] && !send[o] &&
                          (credit[o] == CRED_MAX);
        end

        rd_en = orphan;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (send[o]) rd_en[send_src[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock_vld[o] <= 1'b0;
                lock_src[o] <= '0;
                rr_ptr[o]   <= '0;
                credit[o]   <= CRED_MAX;
                out_q[o]    <= '0;
            end
            error <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_q[o] <= send[o] ? {front[send_src[o]], 1'b1} : '0;
                if (send[o]) begin
                    if (!lock_vld[o]) begin
                        rr_ptr[o] <= next_port(send_src[o]);
                        if (!is_tail[send_src[o]]) begin
                            lock_vld[o] <= 1'b1;
                            lock_src[o] <= send_src[o];
                        end
                    end else if (is_tail[send_src[o]]) begin
                        lock_vld[o] <= 1'b0;
                    end
                end
                unique case ({send[o], flow_ctrl_in_op[o]})
                    2'b10:   credit[o] <= credit[o] - CRED_ONE;
                    2'b01:   if (credit[o] != CRED_MAX)
                                 credit[o] <= credit[o] + CRED_ONE;
                    default: credit[o] <= credit[o];
                endcase
            end
            error <= error | (|overflow) | (|orphan) |
                     (|uturn) | (|cred_ovf);
        end
    end

endmodule
